// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared scalar types, fetch slot record, fetch FSM states and constants
package common_pkg;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;
endpackage

package fetch_stage_pkg;
    import common_pkg::*;
    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
        logic exc;
    } fetch_data_t;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_KILL} fetch_state_t;
    localparam u64 PCINIT_DEF = 64'h8000_0000;
    localparam u32 INSTR_NOP  = 32'h0000_0013;
endpackage

// File: rtl/fetch_holdbuf.sv
// fetch_holdbuf: one-entry skid buffer for a fetched word that arrived while decode stalled
import fetch_stage_pkg::*;

module fetch_holdbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  fetch_data_t d,
    output fetch_data_t q,
    output logic        valid
);
    assign valid = q.valid;
    // clear wins over load so a redirect always empties the buffer
    always_ff @(posedge clk) begin
        if (reset || clear) q <= '0;
        else if (load) q <= d;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC; optional misaligned-PC trap via FETCH_MISALIGN_TRAP_EN
import common_pkg::*;
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter u64 PCINIT = PCINIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_raw_instr,
    output logic        f_exc
);
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif
    fetch_state_t state, state_n;
    u64 pc, pc_n, addr_q, tgt;
    fetch_data_t f, f_n, hb_d, hb_q, entry, trap;
    logic hb_load, hb_clr, hb_valid, busy, mis;

    fetch_holdbuf u_holdbuf (
        .clk(clk), .reset(reset), .load(hb_load), .clear(hb_clr),
        .d(hb_d), .q(hb_q), .valid(hb_valid)
    );

    assign mis         = TRAP_EN && state == S_REQ && pc[1:0] != 2'b00;
    assign tgt         = TRAP_EN ? redirect_pc : redirect_pc & ~64'd3;
    assign busy        = f.valid && stall;
    assign entry       = '{valid: 1'b1, pc: pc, raw_instr: iresp_data, exc: 1'b0};
    assign trap        = '{valid: 1'b1, pc: pc, raw_instr: INSTR_NOP, exc: 1'b1};
    assign ireq_valid  = !reset && state != S_HOLD && !mis;
    assign ireq_addr   = reset ? 64'd0 : (state == S_REQ ? pc : addr_q);
    assign f_valid     = f.valid;
    assign f_pc        = f.pc;
    assign f_raw_instr = f.raw_instr;
    assign f_exc       = f.exc & TRAP_EN;

    // next state, pc and fetch slot; redirect is applied last so it overrides everything
    always_comb begin
        state_n = state;
        pc_n    = pc;
        f_n     = f;
        hb_d    = entry;
        hb_load = 1'b0;
        hb_clr  = 1'b0;
        if (f.valid && !stall) f_n.valid = 1'b0;
        case (state)
            S_REQ, S_WAIT: begin
                if (mis) begin
                    hb_d    = trap;
                    hb_load = busy;
                    if (!busy) f_n = trap;
                    state_n = S_HOLD;
                end else if (iresp_data_ok) begin
                    pc_n    = pc + 64'd4;
                    hb_load = busy;
                    if (!busy) f_n = entry;
                    state_n = busy ? S_HOLD : S_REQ;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_HOLD: begin
                if (!stall && hb_valid) begin
                    f_n     = hb_q;
                    hb_clr  = 1'b1;
                    state_n = hb_q.exc ? S_HOLD : S_REQ;
                end
            end
            default: state_n = iresp_data_ok ? S_REQ : S_KILL;
        endcase
        if (redirect_valid) begin
            pc_n      = tgt;
            f_n.valid = 1'b0;
            hb_load   = 1'b0;
            hb_clr    = 1'b1;
            state_n   = ((state == S_WAIT && !iresp_data_ok) || state == S_KILL) ? S_KILL : S_REQ;
        end
    end

    // state registers; addr_q remembers the address of the outstanding request for WAIT/KILL
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_REQ;
            pc     <= PCINIT;
            addr_q <= '0;
            f      <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            f      <= f_n;
            if (state == S_REQ) addr_q <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage with a same-cycle memory model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, ireq_valid, iresp_data_ok, stall, redirect_valid;
    logic        f_valid, f_exc, auto_ok, man_ok;
    logic [63:0] ireq_addr, redirect_pc, f_pc;
    logic [31:0] iresp_data, f_raw_instr;
    int          total = 0;
    int          passed = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .f_valid(f_valid),
        .f_pc(f_pc), .f_raw_instr(f_raw_instr), .f_exc(f_exc)
    );

    always #5 clk = ~clk;

    // memory returns the low address word as the instruction
    assign iresp_data_ok = (auto_ok && ireq_valid) || man_ok;
    assign iresp_data    = ireq_addr[31:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; auto_ok = 1'b0; man_ok = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        check("rst_ireq_valid", ireq_valid, 0);
        check("rst_ireq_addr", ireq_addr, 0);
        check("rst_f_valid", f_valid, 0);
        check("rst_f_pc", f_pc, 0);
        check("rst_f_raw", f_raw_instr, 0);
        check("rst_f_exc", f_exc, 0);
        reset = 1'b0; auto_ok = 1'b1;
        #1;
        check("t1_addr0", ireq_addr, 64'h8000_0000);
        check("t1_valid0", ireq_valid, 1);
        step();
        check("t1_addr1", ireq_addr, 64'h8000_0004);
        check("t1_fpc0", f_pc, 64'h8000_0000);
        check("t1_fvalid0", f_valid, 1);
        step();
        check("t1_addr2", ireq_addr, 64'h8000_0008);
        check("t1_fpc1", f_pc, 64'h8000_0004);
        check("t1_fraw1", f_raw_instr, 64'h8000_0004);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0000;
        step();
        redirect_valid = 1'b0;
        check("t2_redir_fvalid", f_valid, 0);
        check("t2_redir_addr", ireq_addr, 64'h8000_0000);
        step();
        stall = 1'b1;
        #1;
        check("t2_fpc_s0", f_pc, 64'h8000_0000);
        check("t2_addr_s0", ireq_addr, 64'h8000_0004);
        step();
        check("t2_hold_ireq", ireq_valid, 0);
        check("t2_fpc_s1", f_pc, 64'h8000_0000);
        check("t2_fvalid_s1", f_valid, 1);
        step();
        check("t2_fpc_s2", f_pc, 64'h8000_0000);
        check("t2_fraw_s2", f_raw_instr, 64'h8000_0000);
        stall = 1'b0;
        step();
        check("t2_fpc_rel", f_pc, 64'h8000_0004);
        check("t2_fraw_rel", f_raw_instr, 64'h8000_0004);
        check("t2_addr_rel", ireq_addr, 64'h8000_0008);
        auto_ok = 1'b0;
        step();
        check("t3_wait_valid", ireq_valid, 1);
        check("t3_wait_addr", ireq_addr, 64'h8000_0008);
        check("t3_consumed", f_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        check("t3_kill_addr", ireq_addr, 64'h8000_0008);
        check("t3_kill_valid", ireq_valid, 1);
        step();
        man_ok = 1'b1;
        step();
        man_ok = 1'b0;
        check("t3_discard", f_valid, 0);
        check("t3_new_addr", ireq_addr, 64'h8000_0100);
        auto_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        check("t4_drop", f_valid, 0);
        check("t4_addr", ireq_addr, 64'h8000_0200);
        step();
        check("t4_fpc", f_pc, 64'h8000_0200);
        check("t4_fvalid", f_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("t5_addr_top", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("t5_wrap", ireq_addr, 64'h0);
        check("t5_fpc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_fraw", f_raw_instr, 64'hFFFF_FFFC);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t6_no_req", ireq_valid, 0);
        step();
        check("t6_fvalid", f_valid, 1);
        check("t6_fexc", f_exc, 1);
        check("t6_fraw", f_raw_instr, 64'h13);
        check("t6_fpc", f_pc, 64'h8000_0102);
        check("t6_halt_req", ireq_valid, 0);
        step();
        check("t6_halted", ireq_valid, 0);
`else
        check("t6_addr", ireq_addr, 64'h8000_0100);
        check("t6_req", ireq_valid, 1);
        step();
        check("t6_fpc", f_pc, 64'h8000_0100);
        check("t6_fexc", f_exc, 0);
`endif
        reset = 1'b1;
        #1;
        check("rst_mid_valid", ireq_valid, 0);
        check("rst_mid_addr", ireq_addr, 0);
        step();
        check("rst_mid_fvalid", f_valid, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
